ahb_sram_ctrl: RTL and testbench
================================

// Module: ahb_sram_ctrl
// PURPOSE
//   AHB-Lite slave that sits directly downstream of the 2-master AHB mux and turns
//   its single master port into single-port synchronous SRAM accesses.
//   Writes are zero-wait and posted through a one-entry write buffer.
//   Reads take 1+RD_WS wait states; pending-write bytes are forwarded into the read data.
// PARAMETERS
//   SZ     64  data width in bits (32 or 64); byte lanes NB=SZ/8, BL=log2(NB)
//   AW     10  SRAM word-address width; word index = HADDR[AW+BL-1:BL]
//   RD_WS  0   extra read wait states beyond the SRAM's 1-cycle latency (0..3)
// PORTS
//   HCLK        in   1      bus clock
//   HRESET      in   1      synchronous, active-high reset
//   HSEL        in   1      slave select (tie 1 when sole slave of the mux)
//   HADDR       in   32     address-phase address
//   HTRANS      in   2      transfer type; HTRANS[1]=NONSEQ/SEQ
//   HWRITE      in   1      1=write
//   HSIZE       in   3      transfer size, 0=byte .. 3=dword
//   HWDATA      in   SZ     data-phase write data
//   HREADY      in   1      bus ready (combined HREADY seen by the mux)
//   HREADYOUT   out  1      slave ready to the mux
//   HRDATA      out  SZ     read data, valid when HREADYOUT=1 in a read data phase
//   sram_ce     out  1      SRAM chip enable, one access per cycle
//   sram_we     out  1      1=write
//   sram_be     out  NB     byte write enables
//   sram_addr   out  AW     SRAM word address
//   sram_wdata  out  SZ     SRAM write data
//   sram_rdata  in   SZ     SRAM read data, valid cycle after a read strobe
// BEHAVIOUR
//   Reset (sync, HRESET=1 at HCLK edge)
//   - HREADYOUT=1; HRDATA=0; sram_ce/we/be=0.
//   - FSM=IDLE; write buffer invalid; any pending write is discarded.
//   Address phase accepted when HSEL & HTRANS[1] & HREADY.
//   - Latch word addr, write flag and byte mask: NB-bit mask of 2^HSIZE ones
//     shifted by HADDR[BL-1:0]. HSIZE>BL gives all ones. Misaligned addresses are
//     unsupported and produce an undefined mask.
//   FSM states: IDLE, WDATA, RD_ISSUE, RD_WAIT, RD_DONE.
//   - IDLE -> WDATA on accepted write; IDLE -> RD_ISSUE on accepted read.
//   - WDATA: HREADYOUT=1. At the edge, wbuf={addr,mask,HWDATA} is loaded and
//     wbuf_valid=1. If a new transfer is accepted in the same cycle, go to WDATA or
//     RD_ISSUE; otherwise go to IDLE.
//   - RD_ISSUE: HREADYOUT=0; sram_ce=1, we=0, addr=latched.
//     -> RD_WAIT if RD_WS>0, else -> RD_DONE.
//   - RD_WAIT: HREADYOUT=0; a counter runs RD_WS cycles; sram_rdata is registered on
//     the first cycle; -> RD_DONE.
//   - RD_DONE: HREADYOUT=1. HRDATA = SRAM data, with each byte b replaced by wbuf
//     byte b when wbuf_valid, addresses match and wbuf mask[b]=1. The next transfer
//     may be accepted here.
//   Read latency: data phase = 2+RD_WS cycles, i.e. HREADYOUT low for 1+RD_WS.
//   Write drain: wbuf goes to SRAM (ce=1, we=1, be=mask) in any cycle where the
//   FSM is not in RD_ISSUE.
//   - wbuf_valid clears at that edge unless it is reloaded in the same edge
//     (WDATA with a drain: old entry drains and the new one loads).
//   - Read has priority; forwarding covers a read that overtakes the buffer.
//   - Two back-to-back writes to the same word: the older entry drains first, so no
//     merge is needed.
//   HTRANS IDLE/BUSY and HSEL=0 produce no SRAM read; the buffer may still drain.
//   HRDATA holds its last value outside read data phases.
// STRUCTURE
//   - Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ and HSIZE_BYTE..DWORD
//     constants, FSM state encoding.
//   - One sub-module ahb_byte_mask(HSIZE, HADDR[BL-1:0]) -> mask[NB-1:0], reused by
//     other AHB slaves.
//   - Forward-merge mux and drain arbitration stay inline.
// TESTING
//   1 Reset for 3 cycles, then release
//     -> HREADYOUT=1, HRDATA=0, sram_ce=0, no SRAM activity while HTRANS=IDLE.
//   2 Dword write 0x1122334455667788 @0x100, then IDLE
//     -> zero-wait; next cycle sram_we=1, sram_addr=0x20, sram_be=0xFF, wdata as written.
//   3 Read @0x100 with RD_WS=0 and RD_WS=2
//     -> HREADYOUT low 1 and 3 cycles respectively; HRDATA=0x1122334455667788.
//   4 Byte write 0xAB @0x103 immediately followed by read @0x100 (buffer not yet drained)
//     -> HRDATA=0x11223344AB667788; buffer drains during RD_DONE.
//   5 Four back-to-back dword writes @0x0..0x18, then read all back
//     -> no wait states on writes; every SRAM word correct; no lost drain.
//   6 HRESET asserted in RD_WAIT with wbuf_valid=1
//     -> next cycle HREADYOUT=1, sram_ce=0, the buffered write never reaches SRAM.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer type and size codes, and the SRAM
// slave controller state encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_DONE
    } sram_state_t;

endpackage

// File: rtl/ahb_byte_mask.sv
// Byte-lane mask for an AHB transfer: 2^hsize ones starting at lane addr_lo.
// Sizes wider than the bus select every lane.
module ahb_byte_mask #(
    parameter int unsigned NB = 8,
    parameter int unsigned BL = $clog2(NB)
) (
    input  logic [2:0]    hsize,
    input  logic [BL-1:0] addr_lo,
    output logic [NB-1:0] mask
);

    always_comb begin
        int unsigned off;
        int unsigned len;
        off  = 32'(addr_lo);
        len  = 32'd1 << hsize;
        mask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if ((32'(hsize) > BL) || ((b >= off) && (b < off + len))) begin
                mask[b] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port synchronous SRAM: zero-wait posted
// writes through a one-entry buffer, reads with 1+RD_WS wait states.
module ahb_sram_ctrl
    import ahb_pkg::*;
#(
    parameter int unsigned SZ    = 64,
    parameter int unsigned AW    = 10,
    parameter int unsigned RD_WS = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [SZ-1:0]     HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [SZ-1:0]     HRDATA,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [SZ/8-1:0]   sram_be,
    output logic [AW-1:0]     sram_addr,
    output logic [SZ-1:0]     sram_wdata,
    input  logic [SZ-1:0]     sram_rdata
);

    localparam int unsigned NB      = SZ / 8;
    localparam int unsigned BL      = $clog2(NB);
    localparam logic [1:0]  WS_LAST = (RD_WS > 0) ? 2'(RD_WS - 1) : 2'd0;

    sram_state_t     state_q, state_d;
    logic            slave_rdy;
    logic            accept;
    logic [NB-1:0]   acc_mask;
    logic [AW-1:0]   addr_q;
    logic [NB-1:0]   mask_q;

    logic            wbuf_valid;
    logic [AW-1:0]   wbuf_addr;
    logic [NB-1:0]   wbuf_mask;
    logic [SZ-1:0]   wbuf_data;
    logic            wbuf_load;
    logic            drain;

    logic [1:0]      ws_cnt;
    logic [SZ-1:0]   rdata_q;
    logic [SZ-1:0]   hrdata_q;
    logic [SZ-1:0]   fwd_src;
    logic [SZ-1:0]   fwd_data;
    logic            fwd_hit;

    logic            unused_haddr;
    assign unused_haddr = ^HADDR[31:AW+BL];

    ahb_byte_mask #(
        .NB (NB),
        .BL (BL)
    ) u_mask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[BL-1:0]),
        .mask    (acc_mask)
    );

    always_comb begin
        slave_rdy = !((state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT));
        accept    = HSEL && HREADY && slave_rdy &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        wbuf_load = (state_q == ST_WDATA);
        drain     = wbuf_valid && (state_q != ST_RD_ISSUE) && !HRESET;
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        case (state_q)
            ST_IDLE, ST_WDATA, ST_RD_DONE: begin
                if (accept) begin
                    state_d = HWRITE ? ST_WDATA : ST_RD_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                HREADYOUT = 1'b0;
                state_d   = (RD_WS > 0) ? ST_RD_WAIT : ST_RD_DONE;
            end
            ST_RD_WAIT: begin
                HREADYOUT = 1'b0;
                if (ws_cnt == WS_LAST) begin
                    state_d = ST_RD_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read strobe wins the port; otherwise the buffered write drains. Both are
    // suppressed while reset is asserted so a pending write is truly discarded.
    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (!HRESET) begin
            if (state_q == ST_RD_ISSUE) begin
                sram_ce   = 1'b1;
                sram_addr = addr_q;
            end else if (wbuf_valid) begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = wbuf_mask;
                sram_addr  = wbuf_addr;
                sram_wdata = wbuf_data;
            end
        end
    end

    // With wait states the buffer drains during RD_WAIT, so the forward merge is
    // applied when SRAM data is captured; in RD_DONE the buffer is then empty.
    always_comb begin
        fwd_src  = ((state_q == ST_RD_DONE) && (RD_WS != 0)) ? rdata_q : sram_rdata;
        fwd_hit  = wbuf_valid && (wbuf_addr == addr_q);
        fwd_data = fwd_src;
        for (int unsigned b = 0; b < NB; b++) begin
            if (fwd_hit && wbuf_mask[b]) begin
                fwd_data[8*b +: 8] = wbuf_data[8*b +: 8];
            end
        end
        HRDATA = (state_q == ST_RD_DONE) ? fwd_data : hrdata_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_IDLE;
            wbuf_valid <= 1'b0;
            ws_cnt     <= 2'd0;
            hrdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wbuf_load) begin
                wbuf_valid <= 1'b1;
            end else if (drain) begin
                wbuf_valid <= 1'b0;
            end
            ws_cnt <= (state_q == ST_RD_WAIT) ? ws_cnt + 2'd1 : 2'd0;
            if (state_q == ST_RD_DONE) begin
                hrdata_q <= fwd_data;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q <= HADDR[AW+BL-1:BL];
            mask_q <= acc_mask;
        end
        if (wbuf_load) begin
            wbuf_addr <= addr_q;
            wbuf_mask <= mask_q;
            wbuf_data <= HWDATA;
        end
        if ((state_q == ST_RD_WAIT) && (ws_cnt == 2'd0)) begin
            rdata_q <= fwd_data;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: two instances (RD_WS=0 and RD_WS=2) on a shared
// stimulus bus, each with its own SRAM; checked against a byte-addressed model.
module tb_ahb_sram_ctrl;
    import ahb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    int          sel;

    logic        rdy0, rdy2, ce0, ce2, we0, we2;
    logic [63:0] rdata0, rdata2, wdata0, wdata2, srd0, srd2;
    logic [7:0]  be0, be2;
    logic [9:0]  addr0, addr2;

    logic        rdy, ce, we;
    logic [63:0] hrdata, swdata;
    logic [7:0]  be;
    logic [9:0]  saddr;

    logic [63:0] mem0 [0:1023];
    logic [63:0] mem2 [0:1023];
    logic [7:0]  ref_b [2][8192];

    bit          tr_wr   [64];
    logic [31:0] tr_addr [64];
    logic [2:0]  tr_size [64];
    logic [63:0] tr_data [64];
    logic [63:0] exp_rdata [64];
    logic [63:0] obs_rdata [64];
    int          obs_waits [64];
    bit          obs_drain [64];
    logic [9:0]  obs_daddr [64];
    logic [7:0]  obs_dbe   [64];

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_ctrl #(.SZ(64), .AW(10), .RD_WS(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && (sel == 0)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRDATA(rdata0),
        .sram_ce(ce0), .sram_we(we0), .sram_be(be0), .sram_addr(addr0),
        .sram_wdata(wdata0), .sram_rdata(srd0)
    );

    ahb_sram_ctrl #(.SZ(64), .AW(10), .RD_WS(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && (sel == 1)), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(rdy2), .HREADYOUT(rdy2), .HRDATA(rdata2),
        .sram_ce(ce2), .sram_we(we2), .sram_be(be2), .sram_addr(addr2),
        .sram_wdata(wdata2), .sram_rdata(srd2)
    );

    always @(posedge HCLK) begin
        if (ce0) begin
            if (we0) begin
                for (int b = 0; b < 8; b++) if (be0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
            end else begin
                srd0 <= mem0[addr0];
            end
        end
        if (ce2) begin
            if (we2) begin
                for (int b = 0; b < 8; b++) if (be2[b]) mem2[addr2][8*b +: 8] <= wdata2[8*b +: 8];
            end else begin
                srd2 <= mem2[addr2];
            end
        end
    end

    always_comb begin
        if (sel == 0) begin
            rdy = rdy0; hrdata = rdata0; ce = ce0; we = we0; be = be0; saddr = addr0; swdata = wdata0;
        end else begin
            rdy = rdy2; hrdata = rdata2; ce = ce2; we = we2; be = be2; saddr = addr2; swdata = wdata2;
        end
    end

    function automatic logic [63:0] ref_word(input int s, input int w);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_b[s][w*8 + k];
        return r;
    endfunction

    function automatic logic [63:0] mem_word(input int s, input int w);
        return (s == 0) ? mem0[w] : mem2[w];
    endfunction

    // Apply transfers in program order to the byte model; reads see all earlier writes.
    task automatic model_seq(input int n);
        for (int i = 0; i < n; i++) begin
            int base, off, len;
            base = int'(tr_addr[i][12:0]) & ~7;
            off  = int'(tr_addr[i][2:0]);
            len  = 1 << tr_size[i];
            if (tr_wr[i]) begin
                for (int k = off; k < off + len; k++) ref_b[sel][base + k] = tr_data[i][8*k +: 8];
            end else begin
                for (int k = 0; k < 8; k++) exp_rdata[i][8*k +: 8] = ref_b[sel][base + k];
            end
        end
    endtask

    task automatic set_tr(input int i, input bit w, input logic [31:0] a,
                          input logic [2:0] s, input logic [63:0] d);
        tr_wr[i] = w; tr_addr[i] = a; tr_size[i] = s; tr_data[i] = d;
    endtask

    task automatic idle(input int n);
        htrans = HTRANS_IDLE;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Pipelined AHB master; entered and left at posedge+1.
    task automatic run_seq(input int n);
        int ai, di, cyc, waits;
        logic r;
        ai = 0; di = -1; cyc = 0; waits = 0;
        while ((ai < n || di >= 0) && cyc < 1000) begin
            if (ai < n) begin
                hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = tr_addr[ai];
                hwrite = tr_wr[ai]; hsize = tr_size[ai];
            end else begin
                htrans = HTRANS_IDLE;
            end
            hwdata = (di >= 0 && tr_wr[di]) ? tr_data[di] : 64'h0;
            @(negedge HCLK);
            r = rdy;
            if (di >= 0) begin
                if (!r) waits++;
                else begin
                    obs_rdata[di] = hrdata; obs_drain[di] = ce && we;
                    obs_daddr[di] = saddr; obs_dbe[di] = be;
                end
            end
            @(posedge HCLK); #1;
            cyc++;
            if (r) begin
                if (di >= 0) obs_waits[di] = waits;
                waits = 0;
                if (ai < n) begin di = ai; ai++; end
                else di = -1;
            end
        end
        htrans = HTRANS_IDLE;
        checks++;
        if (cyc >= 1000) begin
            errors++;
            $display("FAIL run_seq_timeout: got %0d cycles, required fewer than 1000", cyc);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge HCLK);
            checks++;
            if ({rdy0, rdy2} !== 2'b11) begin
                errors++; $display("FAIL reset_hreadyout: got %b required 11", {rdy0, rdy2});
            end
            checks++;
            if (rdata0 !== 64'h0 || rdata2 !== 64'h0) begin
                errors++; $display("FAIL reset_hrdata: got %h/%h required 0", rdata0, rdata2);
            end
            checks++;
            if ({ce0, ce2} !== 2'b00) begin
                errors++; $display("FAIL reset_sram_ce: got %b required 00", {ce0, ce2});
            end
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_write_drain();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            set_tr(0, 1, 32'h100, HSIZE_DWORD, 64'h1122334455667788);
            model_seq(1);
            run_seq(1);
            checks++;
            if (obs_waits[0] !== 0) begin
                errors++; $display("FAIL write_waits[%0d]: got %0d required 0", s, obs_waits[0]);
            end
            checks++;
            if ({ce, we, saddr, be, swdata} !== {1'b1, 1'b1, 10'h20, 8'hFF, 64'h1122334455667788}) begin
                errors++;
                $display("FAIL write_drain[%0d]: got ce=%b we=%b addr=%h be=%h wdata=%h required 1 1 020 ff 1122334455667788",
                         s, ce, we, saddr, be, swdata);
            end
            idle(1);
        end
    endtask

    task automatic test_read_latency();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            set_tr(0, 0, 32'h100, HSIZE_DWORD, 64'h0);
            model_seq(1);
            run_seq(1);
            checks++;
            if (obs_waits[0] !== (s == 0 ? 1 : 3)) begin
                errors++; $display("FAIL read_waits[%0d]: got %0d required %0d", s, obs_waits[0], (s == 0 ? 1 : 3));
            end
            checks++;
            if (obs_rdata[0] !== exp_rdata[0]) begin
                errors++; $display("FAIL read_data[%0d]: got %h required %h", s, obs_rdata[0], exp_rdata[0]);
            end
            idle(1);
        end
    endtask

    task automatic test_forward();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            set_tr(0, 1, 32'h103, HSIZE_BYTE, 64'h00000000_AB000000);
            set_tr(1, 0, 32'h100, HSIZE_DWORD, 64'h0);
            model_seq(2);
            run_seq(2);
            checks++;
            if (obs_rdata[1] !== exp_rdata[1]) begin
                errors++; $display("FAIL fwd_data[%0d]: got %h required %h", s, obs_rdata[1], exp_rdata[1]);
            end
            if (s == 0) begin
                checks++;
                if ({obs_drain[1], obs_daddr[1], obs_dbe[1]} !== {1'b1, 10'h20, 8'h08}) begin
                    errors++;
                    $display("FAIL fwd_drain_in_done: got we=%b addr=%h be=%h required 1 020 08",
                             obs_drain[1], obs_daddr[1], obs_dbe[1]);
                end
            end
            idle(2);
            checks++;
            if (mem_word(s, 32) !== ref_word(s, 32)) begin
                errors++; $display("FAIL fwd_sram[%0d]: got %h required %h", s, mem_word(s, 32), ref_word(s, 32));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 4; i++) set_tr(i, 1, 32'(i * 8), HSIZE_DWORD, {$urandom, $urandom});
            for (int i = 0; i < 4; i++) set_tr(4 + i, 0, 32'(i * 8), HSIZE_DWORD, 64'h0);
            model_seq(8);
            run_seq(8);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_waits[i] !== 0) begin
                    errors++; $display("FAIL b2b_write_waits[%0d.%0d]: got %0d required 0", s, i, obs_waits[i]);
                end
                checks++;
                if (obs_rdata[4 + i] !== tr_data[i]) begin
                    errors++; $display("FAIL b2b_read[%0d.%0d]: got %h required %h", s, i, obs_rdata[4 + i], tr_data[i]);
                end
            end
            idle(2);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_word(s, i) !== tr_data[i]) begin
                    errors++; $display("FAIL b2b_sram[%0d.%0d]: got %h required %h", s, i, mem_word(s, i), tr_data[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 48; i++) begin
                int sz, off;
                sz  = int'($urandom_range(3, 0));
                off = (int'($urandom_range(7, 0)) >> sz) << sz;
                set_tr(i, bit'($urandom_range(1, 0)), 32'(int'($urandom_range(7, 0)) * 8 + off),
                       3'(sz), {$urandom, $urandom});
            end
            model_seq(48);
            run_seq(48);
            for (int i = 0; i < 48; i++) begin
                checks++;
                if (obs_waits[i] !== (tr_wr[i] ? 0 : (s == 0 ? 1 : 3))) begin
                    errors++; $display("FAIL rand_waits[%0d.%0d]: got %0d", s, i, obs_waits[i]);
                end
                if (!tr_wr[i]) begin
                    checks++;
                    if (obs_rdata[i] !== exp_rdata[i]) begin
                        errors++; $display("FAIL rand_read[%0d.%0d]: got %h required %h", s, i, obs_rdata[i], exp_rdata[i]);
                    end
                end
            end
            idle(2);
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (mem_word(s, w) !== ref_word(s, w)) begin
                    errors++; $display("FAIL rand_sram[%0d.%0d]: got %h required %h", s, w, mem_word(s, w), ref_word(s, w));
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        sel = 1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h40; hsize = HSIZE_DWORD;
        @(posedge HCLK); #1;
        hwdata = {$urandom, $urandom} | 64'h1;
        hwrite = 1'b0; haddr = 32'h48;
        @(posedge HCLK); #1;
        htrans = HTRANS_IDLE;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        checks++;
        if ({rdy, ce} !== 2'b00) begin
            errors++; $display("FAIL rst_wait_during: got rdy=%b ce=%b required 0 0", rdy, ce);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++;
        if ({rdy, ce, hrdata} !== {1'b1, 1'b0, 64'h0}) begin
            errors++; $display("FAIL rst_wait_after: got rdy=%b ce=%b hrdata=%h required 1 0 0", rdy, ce, hrdata);
        end
        @(posedge HCLK); #1;
        idle(3);
        checks++;
        if (mem_word(1, 8) !== ref_word(1, 8)) begin
            errors++; $display("FAIL rst_wait_discard: got %h required %h", mem_word(1, 8), ref_word(1, 8));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem0[i] = 64'h0; mem2[i] = 64'h0; end
        for (int s = 0; s < 2; s++) for (int i = 0; i < 8192; i++) ref_b[s][i] = 8'h0;
        srd0 = 64'h0; srd2 = 64'h0;
        sel = 0; hsel = 1'b1; haddr = 32'h0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_DWORD; hwdata = 64'h0;
        test_reset();
        test_write_drain();
        test_read_latency();
        test_forward();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
